// File: rtl/debounce_onepulse_vector.sv
// Purpose: per-channel 2-flop sync + debounce of active-low buttons, with one-cycle active-low edge pulses.
// Latency: input change before edge N is accepted (level and pulse) on edge N+1+DEBOUNCE_CYCLES.
// Backpressure: none; free-running, every channel independent. Optional macro: ONEPULSE_AUTOREPEAT_EN.
module debounce_onepulse_vector #(
   parameter int SIGNAL_BIT_WIDTH = 8,
   parameter int DEBOUNCE_CYCLES  = 4,
   parameter int EDGE_MODE        = 0,
   parameter int HOLD_CYCLES      = 16,
   parameter int REPEAT_CYCLES    = 8
) (
   input  logic                        clk_op,
   input  logic                        reset,
   input  logic [SIGNAL_BIT_WIDTH-1:0] signals_n,
   output logic [SIGNAL_BIT_WIDTH-1:0] signals_onepulsed_n,
   output logic [SIGNAL_BIT_WIDTH-1:0] signals_debounced_n
);

   // Out-of-range edge modes fall back to press-only.
   localparam int MODE          = (EDGE_MODE < 0 || EDGE_MODE > 2) ? 0 : EDGE_MODE;
   localparam bit PULSE_PRESS   = (MODE != 1);
   localparam bit PULSE_RELEASE = (MODE != 0);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   // Acceptance happens on the edge where the count would reach DEBOUNCE_CYCLES.
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [SIGNAL_BIT_WIDTH-1:0] sync1;
   logic [SIGNAL_BIT_WIDTH-1:0] sync2;
   logic [DB_W-1:0]             db_cnt [SIGNAL_BIT_WIDTH];
   logic [SIGNAL_BIT_WIDTH-1:0] accept;
   logic [SIGNAL_BIT_WIDTH-1:0] press_acc;
   logic [SIGNAL_BIT_WIDTH-1:0] rel_acc;
   logic [SIGNAL_BIT_WIDTH-1:0] rpt_fire;

   // Two-flop synchroniser for the asynchronous button pins.
   always_ff @(posedge clk_op) begin
      if (reset) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= signals_n;
         sync2 <= sync1;
      end
   end

   // Acceptance decode: sampled level differs and has persisted long enough.
   always_comb begin
      accept    = '0;
      press_acc = '0;
      rel_acc   = '0;
      for (int i = 0; i < SIGNAL_BIT_WIDTH; i++) begin
         accept[i]    = (sync2[i] != signals_debounced_n[i]) && (db_cnt[i] >= DB_LAST);
         press_acc[i] = accept[i] && !sync2[i];
         rel_acc[i]   = accept[i] && sync2[i];
      end
   end

   // Debounce counters and accepted levels; counter saturates rather than wrapping.
   always_ff @(posedge clk_op) begin
      if (reset) begin
         signals_debounced_n <= '1;
         for (int i = 0; i < SIGNAL_BIT_WIDTH; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SIGNAL_BIT_WIDTH; i++) begin
            if (sync2[i] == signals_debounced_n[i]) begin
               db_cnt[i] <= '0;
            end else if (accept[i]) begin
               signals_debounced_n[i] <= sync2[i];
               db_cnt[i]              <= '0;
            end else if (db_cnt[i] != DB_W'(DEBOUNCE_CYCLES)) begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

`ifdef ONEPULSE_AUTOREPEAT_EN
   localparam int HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int HR_W   = $clog2(HR_MAX + 1);
   localparam logic [HR_W-1:0] HOLD_LAST = HR_W'(HOLD_CYCLES - 1);
   localparam logic [HR_W-1:0] REP_LAST  = HR_W'(REPEAT_CYCLES - 1);

   logic [HR_W-1:0]             hold_cnt [SIGNAL_BIT_WIDTH];
   logic [SIGNAL_BIT_WIDTH-1:0] in_repeat;

   // Repeat pulse is due when the held channel's counter hits the current interval;
   // an accepted release on the same edge suppresses it.
   always_comb begin
      rpt_fire = '0;
      for (int i = 0; i < SIGNAL_BIT_WIDTH; i++) begin
         rpt_fire[i] = PULSE_PRESS && !signals_debounced_n[i] && !rel_acc[i] &&
                       (in_repeat[i] ? (hold_cnt[i] >= REP_LAST) : (hold_cnt[i] >= HOLD_LAST));
      end
   end

   // Hold counter runs only while the debounced level is pressed; first interval is
   // HOLD_CYCLES, later intervals REPEAT_CYCLES.
   always_ff @(posedge clk_op) begin
      if (reset) begin
         in_repeat <= '0;
         for (int i = 0; i < SIGNAL_BIT_WIDTH; i++) begin
            hold_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SIGNAL_BIT_WIDTH; i++) begin
            if (signals_debounced_n[i] || rel_acc[i]) begin
               hold_cnt[i]  <= '0;
               in_repeat[i] <= 1'b0;
            end else if (rpt_fire[i]) begin
               hold_cnt[i]  <= '0;
               in_repeat[i] <= 1'b1;
            end else if (hold_cnt[i] != HR_W'(HR_MAX)) begin
               hold_cnt[i] <= hold_cnt[i] + HR_W'(1);
            end
         end
      end
   end
`else
   assign rpt_fire = '0;
`endif

   // Registered pulse output: low for the single edge of a matching acceptance or repeat.
   always_ff @(posedge clk_op) begin
      if (reset) begin
         signals_onepulsed_n <= '1;
      end else begin
         signals_onepulsed_n <= ~((press_acc & {SIGNAL_BIT_WIDTH{PULSE_PRESS}}) |
                                  (rel_acc   & {SIGNAL_BIT_WIDTH{PULSE_RELEASE}}) |
                                  rpt_fire);
      end
   end

endmodule

// File: doc/debounce_onepulse_vector.md
Name: debounce_onepulse_vector

Overview:
Parametrised successor to the existing one-pulse vector. It takes a vector of raw, asynchronous, active-low pushbutton lines and synchronises and debounces each one independently. On selectable edges of each debounced line it emits a single-cycle active-low pulse. The block sits between the board pushbutton pins and the control FSMs, and also exports the debounced level vector.

Parameters:
SIGNAL_BIT_WIDTH, 8, number of independent channels
DEBOUNCE_CYCLES, 4, consecutive cycles a new sampled level must persist before acceptance (>=1)
EDGE_MODE, 0, 0 = pulse on press (1->0), 1 = pulse on release (0->1), 2 = both; values >2 behave as 0
HOLD_CYCLES, 16, auto-repeat: cycles from press acceptance to first repeat pulse (>=1)
REPEAT_CYCLES, 8, auto-repeat: period between subsequent repeat pulses (>=1)

Ports:
clk_op  input  1  operating clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
signals_n  input  SIGNAL_BIT_WIDTH  raw active-low inputs, asynchronous to clk_op
signals_onepulsed_n  output  SIGNAL_BIT_WIDTH  registered active-low one-cycle pulses
signals_debounced_n  output  SIGNAL_BIT_WIDTH  registered debounced active-low levels

Behaviour:
- Reset state, entered on the clk_op edge where reset=1:
  - 2-flop synchroniser = all 1
  - debounced = all 1 (released); signals_debounced_n = all 1
  - signals_onepulsed_n = all 1
  - all counters = 0
  - reset overrides every other event on that edge; a pulse due on that edge is dropped
- Per channel i, all channels fully independent:
  - sync2[i] is the 2-flop synchronised input.
  - If sync2[i] == debounced[i]: debounce counter clears to 0.
  - Otherwise the counter increments. On the edge where it would reach DEBOUNCE_CYCLES, debounced[i] <= sync2[i] and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES sampled cycles causes no level change and no pulse.
- Latency:
  - Input changes before edge N; sync2 reflects it after edge N+1.
  - debounced[i] and the pulse both update on edge N+1+DEBOUNCE_CYCLES.
- Pulse generation:
  - signals_onepulsed_n[i] is driven 0 for exactly one cycle when an accepted transition matches EDGE_MODE; otherwise it is 1.
  - It never stays low two consecutive cycles from the same transition.
- Simultaneous acceptance on several channels produces simultaneous pulses in the same cycle.
- After reset, a button already held low is treated as a new press: it is accepted after the normal latency and pulses if EDGE_MODE is 0 or 2.
- Counter widths are $clog2(max(param)+1); counters saturate and never wrap.

Optional Feature:
Macro ONEPULSE_AUTOREPEAT_EN.
- Defined, and EDGE_MODE is 0 or 2:
  - While debounced[i]=0, a per-channel hold counter runs.
  - An extra pulse is emitted HOLD_CYCLES cycles after the press pulse, then every REPEAT_CYCLES cycles.
  - Accepted release, or reset, clears the counter immediately; no repeat pulse is emitted on the release edge.
  - EDGE_MODE=1 ignores auto-repeat.
- Undefined:
  - Hold counter logic is absent; HOLD_CYCLES and REPEAT_CYCLES are unused.
  - One pulse per accepted matching transition only.

Test Plan:
Common setup: SIGNAL_BIT_WIDTH=8, DEBOUNCE_CYCLES=4, EDGE_MODE=0, HOLD_CYCLES=16, REPEAT_CYCLES=8, clk_op period 10.
1. Reset with signals_n=8'hFF -> both outputs 8'hFF during reset and after reset deasserts; no pulses for 20 cycles.
2. signals_n=8'hFE for 3 cycles, then 8'hFF -> signals_debounced_n stays 8'hFF; signals_onepulsed_n stays 8'hFF throughout.
3. signals_n=8'hFE held 30 cycles, macro undefined -> on edge N+5 signals_debounced_n=8'hFE and signals_onepulsed_n=8'hFE for exactly one cycle; then 8'hFF; release gives no pulse.
4. EDGE_MODE=2; bits 0 and 3 pressed together, held 10 cycles, then released -> 8'hF6 pulse for one cycle at press acceptance; 8'hF6 pulse for one cycle at release acceptance.
5. ONEPULSE_AUTOREPEAT_EN defined, bit0 held 45 cycles past acceptance -> pulses 8'hFE at acceptance +0, +16, +24, +32, +40; released -> no further pulses.
6. Reset asserted on the edge where the bit0 press pulse is due -> signals_onepulsed_n stays 8'hFF; after reset deasserts with bit0 still low -> pulse 8'hFE one cycle, 5 edges after first post-reset sampling edge.
